// File: rtl/syn_fifo_mc_pkg.sv
// syn_fifo_mc_pkg: shared sizing helpers and default constants for the multi-channel FIFO
package syn_fifo_mc_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int cnt_width(input int abw);
        return abw + 1;
    endfunction

    function automatic int addr_width(input int cbw, input int abw);
        return cbw + abw;
    endfunction

    localparam int DEF_DBITWIDTH = 32;
    localparam int DEF_ABITWIDTH = 4;
    localparam int DEF_NCH       = 4;
    localparam int DEF_CBITWIDTH = clog2(DEF_NCH);
    localparam int DEF_CNT_W     = cnt_width(DEF_ABITWIDTH);
    localparam int DEF_ADDR_W    = addr_width(DEF_CBITWIDTH, DEF_ABITWIDTH);

endpackage

// File: rtl/syn_fifo_mc_ram.sv
// syn_fifo_mc_ram: shared storage, one synchronous write port and one asynchronous read port
module syn_fifo_mc_ram #(
    parameter int DW = 32,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // storage is never cleared; queued data is tracked purely by pointers
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/syn_fifo_mc.sv
// syn_fifo_mc: single-clock multi-channel FIFO over one partitioned RAM; optional registered read port via SYN_FIFO_MC_DOUT_REG_EN
module syn_fifo_mc
    import syn_fifo_mc_pkg::*;
#(
    parameter int DBITWIDTH    = DEF_DBITWIDTH,
    parameter int ABITWIDTH    = DEF_ABITWIDTH,
    parameter int NCH          = DEF_NCH,
    parameter int CBITWIDTH    = DEF_CBITWIDTH,
    parameter int AF_THRESHOLD = 12
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 write,
    input  logic [CBITWIDTH-1:0] wr_ch,
    input  logic [DBITWIDTH-1:0] write_data,
    input  logic                 read,
    input  logic [CBITWIDTH-1:0] rd_ch,
    output logic [DBITWIDTH-1:0] read_data,
    output logic                 rd_valid,
    output logic [NCH-1:0]       empty,
    output logic [NCH-1:0]       full,
    output logic [NCH-1:0]       almost_full,
    output logic                 wr_err,
    output logic                 rd_err
);

    localparam int CW = cnt_width(ABITWIDTH);
    localparam int AW = addr_width(CBITWIDTH, ABITWIDTH);

    logic [NCH-1:0][ABITWIDTH-1:0] wr_ptr_v, rd_ptr_v;
    logic [ABITWIDTH-1:0]          wr_ptr_sel, rd_ptr_sel;
    logic [2**CBITWIDTH-1:0]       full_x, empty_x;
    logic                          wr_ok, rd_ok;
    logic [DBITWIDTH-1:0]          ram_rdata;

    // unused channel codes read as full and empty so requests to them are dropped
    always_comb begin
        full_x = '1;
        empty_x = '1;
        full_x[NCH-1:0] = full;
        empty_x[NCH-1:0] = empty;
        wr_ptr_sel = '0;
        rd_ptr_sel = '0;
        for (int c = 0; c < NCH; c++) begin
            if (wr_ch == CBITWIDTH'(c)) wr_ptr_sel = wr_ptr_v[c];
            if (rd_ch == CBITWIDTH'(c)) rd_ptr_sel = rd_ptr_v[c];
        end
    end

    assign rd_ok = read & ~empty_x[rd_ch];
    assign wr_ok = write & (~full_x[wr_ch] | (rd_ok & (rd_ch == wr_ch)));

    syn_fifo_mc_ram #(.DW(DBITWIDTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr ({wr_ch, wr_ptr_sel}),
        .wdata (write_data),
        .raddr ({rd_ch, rd_ptr_sel}),
        .rdata (ram_rdata)
    );

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [ABITWIDTH-1:0] wr_ptr, rd_ptr;
        logic [CW-1:0]        cnt, cnt_n;
        logic                 wr_hit, rd_hit, empty_r, full_r, af_r;
        assign wr_hit = wr_ok & (wr_ch == CBITWIDTH'(c));
        assign rd_hit = rd_ok & (rd_ch == CBITWIDTH'(c));
        assign cnt_n = (wr_hit == rd_hit) ? cnt : wr_hit ? cnt + 1'b1 : cnt - 1'b1;
        assign wr_ptr_v[c] = wr_ptr;
        assign rd_ptr_v[c] = rd_ptr;
        assign empty[c] = empty_r;
        assign full[c] = full_r;
        assign almost_full[c] = af_r;
        // status is registered from the next count so it always matches cnt
        always_ff @(posedge clk) begin
            if (clr) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                cnt     <= '0;
                empty_r <= 1'b1;
                full_r  <= 1'b0;
                af_r    <= 1'b0;
            end else begin
                wr_ptr  <= wr_ptr + ABITWIDTH'(wr_hit);
                rd_ptr  <= rd_ptr + ABITWIDTH'(rd_hit);
                cnt     <= cnt_n;
                empty_r <= cnt_n == '0;
                full_r  <= cnt_n[ABITWIDTH];
                af_r    <= cnt_n >= CW'(AF_THRESHOLD);
            end
        end
    end

    // one-cycle error pulses for dropped requests
    always_ff @(posedge clk) begin
        if (clr) begin
            wr_err <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            wr_err <= write & ~wr_ok;
            rd_err <= read & ~rd_ok;
        end
    end

`ifdef SYN_FIFO_MC_DOUT_REG_EN
    // registered read port: capture the head word on each accepted read, hold otherwise
    always_ff @(posedge clk) begin
        if (clr) begin
            read_data <= '0;
            rd_valid  <= 1'b0;
        end else begin
            read_data <= rd_ok ? ram_rdata : read_data;
            rd_valid  <= rd_ok;
        end
    end
`else
    assign read_data = ram_rdata;
    assign rd_valid = rd_ok;
`endif

endmodule

// File: tb/tb_syn_fifo_mc.sv
// tb_syn_fifo_mc: randomized and directed checks of syn_fifo_mc against per-channel queue model
module tb_syn_fifo_mc;

    localparam int DW    = 32;
    localparam int NCH   = 4;
    localparam int CBW   = 2;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic           clk = 1'b0;
    logic           clr, write, read;
    logic [CBW-1:0] wr_ch, rd_ch;
    logic [DW-1:0]  write_data, read_data;
    logic           rd_valid, wr_err, rd_err;
    logic [NCH-1:0] empty, full, almost_full;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] q [NCH][$];
    logic [DW-1:0] last_data = '0;

    syn_fifo_mc dut (
        .clk         (clk),
        .clr         (clr),
        .write       (write),
        .wr_ch       (wr_ch),
        .write_data  (write_data),
        .read        (read),
        .rd_ch       (rd_ch),
        .read_data   (read_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .wr_err      (wr_err),
        .rd_err      (rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCH-1:0] model_status(input int kind);
        logic [NCH-1:0] s;
        for (int c = 0; c < NCH; c++) begin
            int n;
            n = q[c].size();
            s[c] = (kind == 0) ? (n == 0) : (kind == 1) ? (n == DEPTH) : (n >= AF);
        end
        return s;
    endfunction

    task automatic chk_status();
        chk("empty", 32'(empty), 32'(model_status(0)));
        chk("full", 32'(full), 32'(model_status(1)));
        chk("almost_full", 32'(almost_full), 32'(model_status(2)));
    endtask

    task automatic step(input logic w, input logic [CBW-1:0] wc, input logic [DW-1:0] wd,
                        input logic r, input logic [CBW-1:0] rc);
        logic          rd_ok, wr_ok;
        logic [DW-1:0] exp_rd;
        @(negedge clk);
        clr = 1'b0;
        write = w;
        wr_ch = wc;
        write_data = wd;
        read = r;
        rd_ch = rc;
        rd_ok = r && q[rc].size() != 0;
        wr_ok = w && (q[wc].size() < DEPTH || (rd_ok && rc == wc));
        exp_rd = rd_ok ? q[rc][0] : '0;
        #1;
`ifndef SYN_FIFO_MC_DOUT_REG_EN
        chk("rd_valid", 32'(rd_valid), 32'(rd_ok));
        if (rd_ok) chk("read_data", read_data, exp_rd);
`endif
        @(posedge clk);
        if (rd_ok) void'(q[rc].pop_front());
        if (wr_ok) q[wc].push_back(wd);
        #1;
        chk("wr_err", 32'(wr_err), 32'(w && !wr_ok));
        chk("rd_err", 32'(rd_err), 32'(r && !rd_ok));
        chk_status();
`ifdef SYN_FIFO_MC_DOUT_REG_EN
        if (rd_ok) last_data = exp_rd;
        chk("rd_valid_reg", 32'(rd_valid), 32'(rd_ok));
        chk("read_data_reg", read_data, last_data);
`endif
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        write = 1'b0;
        read = 1'b0;
        @(posedge clk);
        for (int c = 0; c < NCH; c++) q[c].delete();
        last_data = '0;
        #1;
        chk_status();
        chk("clr_wr_err", 32'(wr_err), 32'(0));
        chk("clr_rd_err", 32'(rd_err), 32'(0));
        chk("clr_rd_valid", 32'(rd_valid), 32'(0));
`ifdef SYN_FIFO_MC_DOUT_REG_EN
        chk("clr_read_data", read_data, '0);
`endif
    endtask

    initial begin
        clr = 1'b1;
        write = 1'b0;
        read = 1'b0;
        wr_ch = '0;
        rd_ch = '0;
        write_data = '0;
        repeat (2) @(posedge clk);
        do_clear();
        for (int i = 0; i < 4; i++) step(1'b1, 2'd2, 32'hA0 + 32'(i), 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, '0, 1'b1, 2'd2);
        for (int i = 0; i < 17; i++) step(1'b1, 2'd0, $urandom, 1'b0, 2'd0);
        step(1'b0, 2'd0, '0, 1'b1, 2'd1);
        step(1'b1, 2'd1, 32'h1111_0001, 1'b1, 2'd1);
        step(1'b0, 2'd0, '0, 1'b1, 2'd1);
        for (int i = 0; i < 16; i++) step(1'b1, 2'd3, $urandom, 1'b0, 2'd0);
        for (int i = 0; i < 40; i++) step(1'b1, 2'd3, $urandom, 1'b1, 2'd3);
        for (int i = 0; i < 8; i++) step(1'b0, 2'd0, '0, 1'b1, 2'd0);
        for (int i = 0; i < 100; i++) step(1'b1, 2'd0, $urandom, 1'b1, 2'd1);
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        do_clear();
        step(1'b0, 2'd0, '0, 1'b1, 2'd0);
        step(1'b1, 2'd2, 32'h5A5A_0001, 1'b0, 2'd0);
        step(1'b1, 2'd2, 32'h5A5A_0002, 1'b1, 2'd2);
        step(1'b0, 2'd0, '0, 1'b1, 2'd2);
        step(1'b0, 2'd0, '0, 1'b0, 2'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
